nlm_input_ctrl: RTL and testbench
=================================

# nlm_input_ctrl

Ingress framer for the NLM denoise pipeline. It receives the raw pixel stream with per-pixel valid, line-sync and frame-sync markers, checks frame geometry, and tags every accepted pixel with its line/column coordinates and a border flag. It is the receiving end of the valid/line_sync/frame_sync protocol that the pipeline's output stage generates, and it feeds the line buffers and window logic.

## Interface
- DATA_WIDTH, 12, pixel width
- IMAGE_WIDTH, 1920, pixels per line (≤ 4096)
- IMAGE_HEIGHT, 1080, lines per frame (≤ 4096, > 2·START_LINE)
- BLOCK_RADIUS, 2, NLM block radius
- WIN_RADIUS, 6, NLM search-window radius; START_LINE = BLOCK_RADIUS + WIN_RADIUS (local)

Ports:
- clk  input  1  clock; the block uses this single clock
- rst  input  1  reset, asynchronous, active-high
- valid_i  input  1  pixel qualifier; gaps are allowed
- frame_sync_i  input  1  first pixel of frame; meaningful only with valid_i
- line_sync_i  input  1  first pixel of each line, including line 0; meaningful only with valid_i
- pix_i  input  DATA_WIDTH  pixel
- valid_o  output  1  accepted pixel on pix_o
- pix_o  output  DATA_WIDTH  registered pixel
- line_cnt_o  output  12  line index of pix_o
- column_cnt_o  output  12  column index of pix_o
- border_o  output  1  pix_o is in the unfilterable border (pass-through region)
- frame_start_o  output  1  pulse with pixel (0,0)
- frame_end_o  output  1  pulse with pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1)
- err_o  output  1  one-cycle protocol-error pulse

## Operation
- Internal counters `col` and `line` hold the coordinates of the next expected pixel. An event is any cycle with valid_i = 1. Cycles with valid_i = 0 change nothing, and sync inputs are ignored in those cycles.
- States:
  - IDLE: no frame in progress.
  - FRONT: lines 0..START_LINE-1.
  - NORMAL: lines START_LINE..IMAGE_HEIGHT-START_LINE-1.
  - POST: the remaining lines.
- IDLE behaviour:
  - Event with frame_sync_i & line_sync_i: accept as (0,0), go to FRONT.
  - Event with frame_sync_i & !line_sync_i: err, stay in IDLE, drop the pixel.
  - Other events: drop silently, no err.
- In-frame checks, applied per event in this priority order:
  1. frame_sync_i & line_sync_i: err pulse, then restart. Accept this pixel as (0,0) with frame_start_o, and go to FRONT.
  2. line_sync_i with col ≠ 0, or frame_sync_i alone: err, drop the pixel, go to IDLE.
  3. col = 0 and !line_sync_i: err, drop the pixel, go to IDLE.
  4. Otherwise accept the pixel at (line, col).
- Counter update on accept:
  - col wraps to 0 at IMAGE_WIDTH-1, and line increments on that wrap.
  - State transitions happen on acceptance of the last pixel of lines START_LINE-1 (FRONT→NORMAL), IMAGE_HEIGHT-START_LINE-1 (NORMAL→POST) and IMAGE_HEIGHT-1 (POST→IDLE; counters clear).
- border_o = 1 unless the pixel lies in the NORMAL lines with START_LINE ≤ column < IMAGE_WIDTH-START_LINE.
- Counters are 12-bit unsigned. Comparisons are made against parameter-derived constants; no overflow is possible within legal parameters.

## Timing
- All outputs are registered. Latency is exactly 1 cycle from the accepting valid_i edge to valid_o and all of its tags.
- valid_o = 1 only for accepted pixels. Dropped pixels produce valid_o = 0.
- err_o is asserted in the cycle after the offending event and lasts one cycle. An erroneous dropped pixel never asserts valid_o.
- Reset value of every output is 0. The state resets to IDLE and both counters to 0.
- Reset asserted mid-frame discards the frame. After release, the block accepts nothing until a new frame_sync_i & line_sync_i event.
- frame_start_o and frame_end_o are qualified by valid_o. They are never both 1 for legal parameters.

## Test plan
Parameters for all scenarios: IMAGE_WIDTH = 16, IMAGE_HEIGHT = 10, BLOCK_RADIUS = 1, WIN_RADIUS = 2 (START_LINE = 3).

- **Contiguous frame:** 160 consecutive valid pixels with correct syncs → 160 valid_o pulses, ending in IDLE.
  - frame_start_o at (0,0); frame_end_o at (9,15).
  - border_o = 0 for exactly 40 pixels: lines 3..6, columns 3..12.
  - err_o never asserts.
- **Gapped frame:** the same frame with valid_i toggling every cycle → identical coordinate and border sequence on valid_o; no err_o.
- **Early line_sync:** line_sync_i asserted at (2,7) → err_o pulse and no valid_o for that pixel. valid_o stays 0 for the rest of the stream until the next frame_sync event, which is accepted as (0,0).
- **Mid-frame frame_sync:** frame_sync_i & line_sync_i asserted at (5,4) → err_o pulse together with valid_o, frame_start_o, and coordinates (0,0). The following pixel is tagged (0,1).
- **Missing line_sync:** at column 0 of line 4 → err_o pulse, pixel dropped, block returns to IDLE.
- **Reset and IDLE noise:**
  - rst asserted at (7,9) → all outputs 0 the next cycle.
  - Subsequent valid_i pixels without syncs → no valid_o, no err_o.
  - frame_sync_i without line_sync_i → err_o pulse only.

Source files
------------

// File: rtl/nlm_input_ctrl.sv
// Ingress framer for the NLM pipeline: validates frame/line sync geometry and
// tags each accepted pixel with its line/column coordinates and a border flag.
module nlm_input_ctrl #(
    parameter int DATA_WIDTH   = 12,
    parameter int IMAGE_WIDTH  = 1920,
    parameter int IMAGE_HEIGHT = 1080,
    parameter int BLOCK_RADIUS = 2,
    parameter int WIN_RADIUS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  frame_sync_i,
    input  logic                  line_sync_i,
    input  logic [DATA_WIDTH-1:0] pix_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] pix_o,
    output logic [11:0]           line_cnt_o,
    output logic [11:0]           column_cnt_o,
    output logic                  border_o,
    output logic                  frame_start_o,
    output logic                  frame_end_o,
    output logic                  err_o
);
    localparam int START_LINE = BLOCK_RADIUS + WIN_RADIUS;

    localparam logic [11:0] COL_LAST        = 12'(IMAGE_WIDTH - 1);
    localparam logic [11:0] LINE_LAST       = 12'(IMAGE_HEIGHT - 1);
    localparam logic [11:0] LINE_FRONT_LAST = 12'(START_LINE - 1);
    localparam logic [11:0] LINE_NORM_LAST  = 12'(IMAGE_HEIGHT - START_LINE - 1);
    localparam logic [11:0] INNER_LO        = 12'(START_LINE);
    localparam logic [11:0] COL_INNER_END   = 12'(IMAGE_WIDTH - START_LINE);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FRONT  = 2'd1;
    localparam logic [1:0] NORMAL = 2'd2;
    localparam logic [1:0] POST   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [11:0] col_q, col_d, line_q, line_d;
    logic        acc, err;
    logic [11:0] a_line, a_col;
    logic        inner;

    logic                  valid_q, border_q, fstart_q, fend_q, err_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [11:0]           line_out_q, col_out_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        acc     = 1'b0;
        err     = 1'b0;
        a_line  = line_q;
        a_col   = col_q;
        if (valid_i) begin
            if (state_q == IDLE) begin
                if (frame_sync_i && line_sync_i) begin
                    acc     = 1'b1;
                    a_line  = '0;
                    a_col   = '0;
                    state_d = FRONT;
                end else if (frame_sync_i) begin
                    err = 1'b1;
                end
            end else if (frame_sync_i && line_sync_i) begin
                // Restart: flag the broken frame but keep the new first pixel.
                err     = 1'b1;
                acc     = 1'b1;
                a_line  = '0;
                a_col   = '0;
                state_d = FRONT;
            end else if ((line_sync_i && col_q != '0) || frame_sync_i ||
                         (col_q == '0 && !line_sync_i)) begin
                err     = 1'b1;
                state_d = IDLE;
                col_d   = '0;
                line_d  = '0;
            end else begin
                acc = 1'b1;
            end
        end
        if (acc) begin
            if (a_col == COL_LAST) begin
                col_d  = '0;
                line_d = a_line + 12'd1;
                if (a_line == LINE_FRONT_LAST) begin
                    state_d = NORMAL;
                end else if (a_line == LINE_NORM_LAST) begin
                    state_d = POST;
                end else if (a_line == LINE_LAST) begin
                    state_d = IDLE;
                    line_d  = '0;
                end
            end else begin
                col_d  = a_col + 12'd1;
                line_d = a_line;
            end
        end
    end

    assign inner = (a_line >= INNER_LO) && (a_line <= LINE_NORM_LAST) &&
                   (a_col >= INNER_LO) && (a_col < COL_INNER_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            line_q     <= '0;
            valid_q    <= 1'b0;
            pix_q      <= '0;
            line_out_q <= '0;
            col_out_q  <= '0;
            border_q   <= 1'b0;
            fstart_q   <= 1'b0;
            fend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            line_q     <= line_d;
            valid_q    <= acc;
            err_q      <= err;
            border_q   <= acc && !inner;
            fstart_q   <= acc && a_line == '0 && a_col == '0;
            fend_q     <= acc && a_line == LINE_LAST && a_col == COL_LAST;
            if (acc) begin
                pix_q      <= pix_i;
                line_out_q <= a_line;
                col_out_q  <= a_col;
            end
        end
    end

    assign valid_o       = valid_q;
    assign pix_o         = pix_q;
    assign line_cnt_o    = line_out_q;
    assign column_cnt_o  = col_out_q;
    assign border_o      = border_q;
    assign frame_start_o = fstart_q;
    assign frame_end_o   = fend_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_nlm_input_ctrl.sv
// Directed bench for nlm_input_ctrl on a 16x10 frame with START_LINE = 3.
module tb_nlm_input_ctrl;
    localparam int W = 16;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0, frame_sync_i = 1'b0, line_sync_i = 1'b0;
    logic [11:0] pix_i = '0;
    logic        valid_o, border_o, frame_start_o, frame_end_o, err_o;
    logic [11:0] pix_o, line_cnt_o, column_cnt_o;

    int nchk = 0;
    int nfail = 0;

    nlm_input_ctrl #(
        .DATA_WIDTH(12), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
        .BLOCK_RADIUS(1), .WIN_RADIUS(2)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .frame_sync_i(frame_sync_i),
        .line_sync_i(line_sync_i), .pix_i(pix_i), .valid_o(valid_o), .pix_o(pix_o),
        .line_cnt_o(line_cnt_o), .column_cnt_o(column_cnt_o), .border_o(border_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; outputs for this event are checked #1 after the edge.
    task automatic send(input logic v, input logic fs, input logic ls, input logic [11:0] p);
        valid_i = v; frame_sync_i = fs; line_sync_i = ls; pix_i = p;
        @(posedge clk); #1;
        valid_i = 1'b0; frame_sync_i = 1'b0; line_sync_i = 1'b0;
    endtask

    function automatic logic [11:0] pval(input int idx);
        logic [11:0] k;
        k = 12'(idx);
        return k ^ 12'h5a5;
    endfunction

    task automatic send_px(input int idx);
        send(1'b1, idx == 0, (idx % W) == 0, pval(idx));
    endtask

    task automatic chk_px(input int idx);
        int l, c;
        l = idx / W;
        c = idx % W;
        chk("valid", valid_o, 1);
        chk("line", line_cnt_o, l);
        chk("col", column_cnt_o, c);
        chk("pix", pix_o, pval(idx));
        chk("border", border_o, !(l >= 3 && l <= 6 && c >= 3 && c <= 12));
        chk("fstart", frame_start_o, idx == 0);
        chk("fend", frame_end_o, idx == W * H - 1);
        chk("err", err_o, 0);
    endtask

    task automatic chk_quiet(input string tag, input logic e);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_err"}, err_o, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int inner_cnt;
        do_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_outs", {pix_o, line_cnt_o, column_cnt_o, border_o, frame_start_o, frame_end_o, err_o}, 0);

        // Contiguous frame
        inner_cnt = 0;
        for (int i = 0; i < W * H; i++) begin
            send_px(i);
            chk_px(i);
            if (valid_o && !border_o) inner_cnt++;
        end
        chk("inner_cnt", inner_cnt, 40);
        send(1'b1, 1'b0, 1'b1, 12'h123);
        chk_quiet("post_frame_idle", 1'b0);

        // Gapped frame
        for (int i = 0; i < W * H; i++) begin
            send(1'b0, 1'b1, 1'b1, 12'hfff);
            chk_quiet("gap", 1'b0);
            send_px(i);
            chk_px(i);
        end

        // Early line_sync at (2,7)
        for (int i = 0; i < 2 * W + 7; i++) send_px(i);
        send(1'b1, 1'b0, 1'b1, 12'h777);
        chk_quiet("early_ls", 1'b1);
        for (int i = 2 * W + 8; i < 5 * W; i++) begin
            send_px(i);
            chk_quiet("early_ls_after", 1'b0);
        end
        send_px(0);
        chk_px(0);

        // Mid-frame restart at (5,4)
        for (int i = 1; i < 5 * W + 4; i++) send_px(i);
        send(1'b1, 1'b1, 1'b1, 12'h0ab);
        chk("mid_err", err_o, 1);
        chk("mid_valid", valid_o, 1);
        chk("mid_fstart", frame_start_o, 1);
        chk("mid_coord", {line_cnt_o, column_cnt_o}, 0);
        chk("mid_pix", pix_o, 12'h0ab);
        send(1'b1, 1'b0, 1'b0, 12'h0ac);
        chk("mid_next_valid", valid_o, 1);
        chk("mid_next_coord", {line_cnt_o, column_cnt_o}, {12'd0, 12'd1});
        chk("mid_next_err", err_o, 0);

        // Missing line_sync at column 0 of line 4
        do_reset();
        for (int i = 0; i < 4 * W; i++) send_px(i);
        send(1'b1, 1'b0, 1'b0, pval(4 * W));
        chk_quiet("miss_ls", 1'b1);
        send(1'b1, 1'b0, 1'b0, pval(4 * W + 1));
        chk_quiet("miss_ls_idle", 1'b0);
        send(1'b1, 1'b0, 1'b1, pval(5 * W));
        chk_quiet("miss_ls_idle2", 1'b0);

        // Reset at (7,9), then IDLE noise
        do_reset();
        for (int i = 0; i < 7 * W + 9; i++) send_px(i);
        chk("pre_rst_valid", valid_o, 1);
        valid_i = 1'b1; pix_i = pval(7 * W + 9); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outs", {valid_o, pix_o, line_cnt_o, column_cnt_o, border_o, frame_start_o, frame_end_o, err_o}, 0);
        rst = 1'b0; valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 1'b0, i[0], 12'(i));
            chk_quiet("noise", 1'b0);
        end
        send(1'b1, 1'b1, 1'b0, 12'h321);
        chk_quiet("fs_only", 1'b1);
        send(1'b0, 1'b0, 1'b0, 12'h0);
        chk_quiet("fs_only_after", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
